// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch and data requesters.
// Tie policy is fixed dm priority, or round-robin when ARB_ROUND_ROBIN_EN is defined.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic              port_dm;
  logic              we_q;
  logic [CNT_W-1:0]  cnt;
  logic              pick_dm;
  logic              can_grant;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm;

  // A tie goes to whichever port was not granted last.
  assign pick_dm = dm_req && (!if_req || !last_dm);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dm <= 1'b0;
    end else if (if_gnt || dm_gnt) begin
      last_dm <= dm_gnt;
    end
  end
`else
  assign pick_dm = dm_req;
`endif

  // Grants are only offered in IDLE and never while reset is being applied.
  assign can_grant = (state == IDLE) && !reset;
  assign dm_gnt    = can_grant && pick_dm;
  assign if_gnt    = can_grant && if_req && !pick_dm;

  // A timeout response only happens with mem_ready still low; writes return 0.
  assign resp_err  = !mem_ready;
  assign resp_data = (mem_ready && !we_q) ? mem_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      port_dm        <= 1'b0;
      we_q           <= 1'b0;
      cnt            <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      if_rvalid      <= 1'b0;
      if_rdata       <= '0;
      if_err         <= 1'b0;
      dm_rvalid      <= 1'b0;
      dm_rdata       <= '0;
      dm_err         <= 1'b0;
      busy           <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
      dm_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (if_gnt || dm_gnt) begin
            port_dm        <= dm_gnt;
            we_q           <= dm_gnt && dm_we;
            mem_address    <= dm_gnt ? dm_addr : if_addr;
            mem_write_data <= dm_gnt ? dm_wdata : '0;
            mem_read       <= !(dm_gnt && dm_we);
            mem_write      <= dm_gnt && dm_we;
            cnt            <= '0;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mem_ready || (cnt == CNT_LAST)) begin
            if (port_dm) begin
              dm_rvalid <= 1'b1;
              dm_rdata  <= resp_data;
              dm_err    <= resp_err;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= resp_data;
              if_err    <= resp_err;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          we_q           <= 1'b0;
          mem_address    <= '0;
          mem_write_data <= '0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_data(mem_data), .mem_ready(mem_ready),
    .busy(busy)
  );

  // mem_arr is the memory seen by the DUT; ref_mem is the model's view of it.
  logic [DATA_W-1:0] mem_arr [64];
  logic [DATA_W-1:0] ref_mem [64];
  int n_tests = 0;
  int n_fail  = 0;
  bit exp_last_dm;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [2:0] EXP_TIE = 3'b101;
`else
  localparam logic [2:0] EXP_TIE = 3'b111;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ctl"}, {if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err,
                          mem_read, mem_write, busy}, '0);
    check({tag, "_bus"}, {if_rdata | dm_rdata, mem_address | mem_write_data}, '0);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
    mem_data = mem_arr[mem_address[7:2]];
  endtask

  function automatic bit pick_dm(input bit ir, input bit dr);
    if (!dr) return 1'b0;
    if (!ir) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    return !exp_last_dm;
`else
    return 1'b1;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0;
    to_next();
    to_next();
    @(negedge clk);
    check_idle_zero("rst_hold");
    to_next();
    reset = 1'b0;
    exp_last_dm = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_out");
    to_next();
  endtask

  // One transaction from the first IDLE cycle until the cycle after RESP.
  task automatic run_txn(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                         input logic [31:0] da, input logic [31:0] dwd, input int stall,
                         input bit tmo, input bit keep, output bit got_dm);
    bit          w_dm;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] exp_rd;
    int          lat;
    w_dm   = pick_dm(ir, dr);
    wr     = w_dm && dwe;
    addr   = w_dm ? da : ia;
    lat    = tmo ? int'(TIMEOUT) + 2 : 3 + stall;
    exp_rd = (tmo || wr) ? 32'h0 : ref_mem[addr[7:2]];
    if (wr) ref_mem[addr[7:2]] = dwd;
    exp_last_dm = w_dm;

    if_req = ir; if_addr = ia;
    dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("gnt", {if_gnt, dm_gnt}, w_dm ? 2'b01 : 2'b10);
    check("idle_ctl", {busy, mem_read, mem_write}, 3'b000);
    check("idle_addr", mem_address, '0);
    got_dm = dm_gnt;
    to_next();
    if (!keep) begin
      if_req = 1'b0; dm_req = 1'b0;
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      dm_we = 1'($urandom_range(0, 1));
    end

    for (int c = 1; c <= lat; c++) begin
      if (c >= 2 && c < lat) mem_ready = tmo ? 1'b0 : ((c - 2) >= stall);
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (mem_write) mem_arr[mem_address[7:2]] = mem_write_data;
      check("busy", busy, 1'b1);
      check("gnt_off", {if_gnt, dm_gnt}, 2'b00);
      check("addr", mem_address, addr);
      check("strobe", {mem_read, mem_write}, (c == 1) ? (wr ? 2'b01 : 2'b10) : 2'b00);
      if (c == 1 && wr) check("wdata", mem_write_data, dwd);
      if (c < lat) begin
        check("no_rvalid", {if_rvalid, dm_rvalid}, 2'b00);
      end else begin
        check("rvalid", {if_rvalid, dm_rvalid}, w_dm ? 2'b01 : 2'b10);
        check("rdata", w_dm ? dm_rdata : if_rdata, exp_rd);
        check("err", w_dm ? dm_err : if_err, tmo);
        check("other_resp", w_dm ? {if_rdata, if_err} : {dm_rdata, dm_err}, '0);
      end
      to_next();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         g;
    logic [2:0] pat;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    do_reset();

    // Directed read of a preloaded word.
    mem_arr[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    run_txn(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, g);

    // Write then read back.
    run_txn(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 0, 1'b0, 1'b0, g);
    check("wr_mem", mem_arr[16], 32'h12345678);
    run_txn(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0, g);

    // Memory hold of 5 cycles, then timeout.
    run_txn(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 5, 1'b0, 1'b0, g);
    run_txn(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 1'b0, g);
    @(negedge clk);
    check("tmo_busy", busy, 1'b0);
    to_next();

    // Tie for three rounds straight after reset.
    do_reset();
    pat = '0;
    for (int r = 0; r < 3; r++) begin
      run_txn(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b1, g);
      pat[2 - r] = g;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    check("tie_order", pat, EXP_TIE);

    // Reset while waiting on memory.
    do_reset();
    if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b0;
    @(negedge clk);
    check("rw_gnt", if_gnt, 1'b1);
    to_next();
    if_req = 1'b0;
    to_next();
    to_next();
    reset = 1'b1;
    @(negedge clk);
    check("rw_busy", busy, 1'b1);
    to_next();
    reset = 1'b0;
    exp_last_dm = 1'b0;
    @(negedge clk);
    check_idle_zero("rw_after");
    for (int k = 0; k < 20; k++) begin
      to_next();
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rw_quiet", {if_rvalid, dm_rvalid, busy}, 3'b000);
    end
    to_next();
    run_txn(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b0, g);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      int sel;
      sel = $urandom_range(0, 2);
      run_txn(sel != 1, $urandom, sel != 0, 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, 4), $urandom_range(0, 9) == 0, 1'b0, g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-ported main memory. It shares the one memory port between the instruction-fetch requester (read-only) and the data-memory requester (read/write). Each accepted transaction is driven onto the memory as a single-cycle read or write strobe, and the result is returned to the granted requester with a valid pulse. A watchdog flags a memory that never asserts ready.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, maximum WAIT cycles with mem_ready low before error (range 2..255)

Ports:
- clk  in  1  single clock; all state on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch request accepted at this edge (combinational, IDLE only)
- if_rvalid  out  1  one-cycle pulse; if_rdata/if_err valid
- if_rdata  out  DATA_W  fetched word
- if_err  out  1  timeout on this response
- dm_req, dm_we  in  1 each  data request; write when dm_we=1
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  DATA_W  write data
- dm_gnt, dm_rvalid, dm_err  out  1 each  as for fetch port
- dm_rdata  out  DATA_W  read word; 0 for writes and errors
- mem_read, mem_write  out  1 each  memory strobes, one cycle each
- mem_address  out  ADDR_W  memory address (byte)
- mem_write_data  out  DATA_W  memory write data
- mem_data  in  DATA_W  memory read data
- mem_ready  in  1  memory data ready
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate, assert the winning gnt, latch port, address, wdata and we into internal registers, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: drive mem_read (read) or mem_write (write) high for exactly one cycle from the latched registers, then go to WAIT. mem_address/mem_write_data hold the latched values from ISSUE through RESP and are 0 in IDLE.
- WAIT: when mem_ready=1, capture mem_data (reads) or 0 (writes), then go to RESP. When mem_ready=0, increment the timeout counter. When the counter reaches TIMEOUT-1, set the error flag with data 0, then go to RESP.
- RESP: pulse the granted port's rvalid, drive rdata/err from registers, then go to IDLE. The other port's response outputs stay 0.
- Requests are never accepted outside IDLE. A req held high is granted in the next IDLE.
- Requester rule: hold req, addr, wdata and we stable until gnt. They may change freely after gnt.
- Both gnt are never high together. rvalid is only ever asserted on the port that was granted.
- Reset (at any state, including mid-transaction): go to IDLE and clear counter, latches and error flag. No rvalid is issued for the dropped transaction; a write strobed before reset is not rolled back. last_grant resets to IF.
- Address is passed through unmodified. The memory performs the word conversion.

## Timing
- Reset values: every output 0, state IDLE.
- Read, memory with mem_ready constant 1: gnt in cycle 0, mem_read in cycle 1, capture in cycle 2, rvalid in cycle 3. Next gnt is possible in cycle 4, so throughput is one transaction per 4 cycles.
- Each cycle that mem_ready is low in WAIT adds one cycle of latency.
- Timeout: rvalid with err=1 occurs TIMEOUT+2 cycles after gnt.
- Simultaneous if_req and dm_req in IDLE: resolved per Configuration.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, grant the port not in last_grant. last_grant updates on every grant. The first tie after reset goes to dm.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, dm always wins a tie. The fetch port can starve under continuous dm_req; this is accepted.
- Single requests behave identically in both builds.

## Test plan
- Read: reset, preload word 0xDEADBEEF at address 0x10, if_req with if_addr=0x10 -> if_gnt in cycle 0, mem_read in cycle 1 only, if_rvalid in cycle 3 with if_rdata=0xDEADBEEF and if_err=0.
- Write then read: dm write of 0x12345678 to 0x40, then dm read of 0x40 -> mem_write single cycle, dm_rvalid with dm_rdata=0; the read returns 0x12345678.
- Tie, three back-to-back rounds with both req held -> fixed build grants order D,D,D; round-robin build grants order D,I,D. Never both gnt in one cycle.
- Memory hold: mem_ready held low for 5 cycles in WAIT -> rvalid arrives 5 cycles later than nominal with correct data and err=0.
- Timeout: mem_ready stuck at 0, TIMEOUT=16 -> rvalid with err=1 and rdata=0 at cycle 18 after gnt; busy then returns to 0.
- Reset in WAIT -> next cycle all outputs are 0 and state is IDLE, no rvalid follows, and a pending req is granted normally afterwards.
